// File: rtl/envseq_pkg.sv
// Shared types and helpers for the ramping envelope sequencer.
// Also supplies a default for the codebase fixed-point width macro BITS.
`ifndef BITS
`define BITS 16
`endif

package envseq_pkg;

   typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} env_state_t;

   // Fraction bits needed so that a delta can be spread over 2^(2^tw-1) ticks.
   function automatic int frac_bits(input int tw);
      return (1 << tw) - 1;
   endfunction

   // Map a DEPTH-bit level onto the unsigned output range, keeping the MSB clear.
   function automatic logic [63:0] scale_level(input logic [31:0] level,
                                               input int depth,
                                               input int out_w);
      return 64'(level) << (out_w - depth - 1);
   endfunction

endpackage

// File: rtl/env_tick_gen.sv
// Trigger edge detector, pending-start flag and TSCALE tick prescaler.
// The edge is captured even while ena is low; it is released by pending_clr.
module env_tick_gen
   import envseq_pkg::*;
#(
   parameter int TSCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic trigger,
   input  logic pending_clr,
   output logic tick,
   output logic pending
);

   localparam int PW = (TSCALE > 1) ? $clog2(TSCALE) : 1;

   logic          trig_q;
   logic          pending_q;
   logic [PW-1:0] presc_q, presc_d;
   logic          edge_det;

   assign edge_det = trigger & ~trig_q;
   assign tick     = ena && (presc_q == PW'(TSCALE - 1));
   assign pending  = pending_q;

   // Prescaler advances only while enabled and wraps on each tick.
   always_comb begin
      presc_d = presc_q;
      if (ena) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
   end

   // Trigger history, sticky pending flag (a new edge beats a clear) and prescaler.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_q    <= 1'b0;
         pending_q <= 1'b0;
         presc_q   <= '0;
      end else begin
         trig_q  <= trigger;
         presc_q <= presc_d;
         if (edge_det) begin
            pending_q <= 1'b1;
         end else if (pending_clr) begin
            pending_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/env_ramp_seq.sv
// Multi-stage linear-ramp envelope sequencer.
// Each stage ramps from the current value to its level in 2^time ticks using a
// fixed-point accumulator, then snaps exactly onto the target.
// Optional build macro ENVSEQ_LOOP_EN adds a loop input that restarts stage 0
// from the final level instead of returning to idle.
module env_ramp_seq
   import envseq_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int STAGES = 4,
   parameter int TW     = 3,
   parameter int TSCALE = 1,
   parameter int OUT_W  = `BITS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ena,
   input  logic                        trigger,
   input  logic [STAGES*DEPTH-1:0]     levels,
   input  logic [STAGES*TW-1:0]        times,
`ifdef ENVSEQ_LOOP_EN
   input  logic                        loop,
`endif
   output logic [OUT_W-1:0]            env_out,
   output logic                        busy,
   output logic [$clog2(STAGES)-1:0]   stage_idx,
   output logic                        eoc
);

   localparam int FRAC  = frac_bits(TW);
   localparam int ACC_W = OUT_W + 1 + FRAC;
   localparam int SW    = $clog2(STAGES);
   localparam int CNT_W = FRAC;

   env_state_t               state_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  step_q;
   logic signed [ACC_W-1:0]  acc_sum;
   logic [CNT_W-1:0]         cnt_q;
   logic [SW-1:0]            stage_q;
   logic [OUT_W-1:0]         env_q;
   logic [OUT_W-1:0]         tgt_q;
   logic                     busy_q;
   logic                     eoc_q;

   logic                     tick;
   logic                     pending;
   logic                     pending_clr;
   logic                     last;
   logic                     loop_go;
   logic [SW-1:0]            nxt_idx;
   logic [DEPTH-1:0]         lvl0, nxt_lvl;
   logic [TW-1:0]            e0, nxt_e;
   logic [OUT_W-1:0]         tgt0, nxt_tgt;

   // Signed delta between two output values, pre-shifted so that 2^e
   // accumulations cover it exactly.
   function automatic logic signed [ACC_W-1:0] ramp_step(input logic [OUT_W-1:0] from_v,
                                                         input logic [OUT_W-1:0] to_v,
                                                         input logic [TW-1:0]    e);
      logic signed [OUT_W:0]   delta;
      logic signed [ACC_W-1:0] wide;
      delta = $signed({1'b0, to_v}) - $signed({1'b0, from_v});
      wide  = ACC_W'(delta);
      return wide <<< (FRAC - int'(e));
   endfunction

   // Ticks remaining after the first one of a 2^e-tick stage.
   function automatic logic [CNT_W-1:0] stage_cnt(input logic [TW-1:0] e);
      return CNT_W'((32'd1 << e) - 32'd1);
   endfunction

   env_tick_gen #(
      .TSCALE (TSCALE)
   ) u_tick (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .trigger     (trigger),
      .pending_clr (pending_clr),
      .tick        (tick),
      .pending     (pending)
   );

   assign pending_clr = tick && pending;
   assign last        = (stage_q == SW'(STAGES - 1));
   assign nxt_idx     = last ? '0 : stage_q + SW'(1);

   assign lvl0    = levels[0 +: DEPTH];
   assign e0      = times[0 +: TW];
   assign nxt_lvl = levels[nxt_idx*DEPTH +: DEPTH];
   assign nxt_e   = times[nxt_idx*TW +: TW];
   assign tgt0    = OUT_W'(scale_level(32'(lvl0), DEPTH, OUT_W));
   assign nxt_tgt = OUT_W'(scale_level(32'(nxt_lvl), DEPTH, OUT_W));
   assign acc_sum = acc_q + step_q;

`ifdef ENVSEQ_LOOP_EN
   assign loop_go = loop;
`else
   assign loop_go = 1'b0;
`endif

   // Sequencer FSM: (re)start on a pending tick, ramp, snap and advance stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         step_q  <= '0;
         cnt_q   <= '0;
         stage_q <= '0;
         env_q   <= '0;
         tgt_q   <= '0;
         busy_q  <= 1'b0;
         eoc_q   <= 1'b0;
      end else begin
         eoc_q <= 1'b0;
         if (tick) begin
            if (pending) begin
               state_q <= RAMP;
               busy_q  <= 1'b1;
               stage_q <= '0;
               cnt_q   <= stage_cnt(e0);
               step_q  <= ramp_step(env_q, tgt0, e0);
               tgt_q   <= tgt0;
            end else if (state_q == RAMP) begin
               if (cnt_q != '0) begin
                  acc_q <= acc_sum;
                  env_q <= acc_sum[FRAC +: OUT_W];
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  acc_q <= $signed({1'b0, tgt_q, {FRAC{1'b0}}});
                  env_q <= tgt_q;
                  if (!last || loop_go) begin
                     stage_q <= nxt_idx;
                     cnt_q   <= stage_cnt(nxt_e);
                     step_q  <= ramp_step(tgt_q, nxt_tgt, nxt_e);
                     tgt_q   <= nxt_tgt;
                     eoc_q   <= last;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     stage_q <= '0;
                     eoc_q   <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign env_out   = env_q;
   assign busy      = busy_q;
   assign stage_idx = stage_q;
   assign eoc       = eoc_q;

endmodule

// File: tb/tb_env_ramp_seq.sv
// Directed bench for env_ramp_seq: levels 15/8/0, time exponents 2/0/1.
// A second instance with TSCALE=3 covers the prescaler.
module tb_env_ramp_seq;

   localparam int DEPTH  = 4;
   localparam int STAGES = 3;
   localparam int TW     = 3;
   localparam int OUT_W  = 16;

   logic                    clk     = 1'b0;
   logic                    rst     = 1'b0;
   logic                    ena     = 1'b1;
   logic                    trigger = 1'b0;
   logic                    ena3    = 1'b1;
   logic                    trig3   = 1'b0;
   logic [STAGES*DEPTH-1:0] levels  = {4'd0, 4'd8, 4'd15};
   logic [STAGES*TW-1:0]    times   = {3'd1, 3'd0, 3'd2};
`ifdef ENVSEQ_LOOP_EN
   logic                    loop_i  = 1'b0;
`endif

   logic [OUT_W-1:0] env_out, env3;
   logic             busy, eoc, busy3, eoc3;
   logic [1:0]       stage_idx, stage3;

   int checks = 0;
   int errors = 0;
   int n;

   int full_env[7]   = '{7680, 15360, 23040, 30720, 16384, 8192, 0};
   int full_stage[7] = '{0, 0, 0, 1, 2, 2, 0};
   int full_eoc[7]   = '{0, 0, 0, 0, 0, 0, 1};
   int retrig_env[5] = '{15360, 19200, 23040, 26880, 30720};

   always #5 clk = ~clk;

   env_ramp_seq #(
      .DEPTH (DEPTH), .STAGES (STAGES), .TW (TW), .TSCALE (1), .OUT_W (OUT_W)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .trigger   (trigger),
      .levels    (levels),
      .times     (times),
`ifdef ENVSEQ_LOOP_EN
      .loop      (loop_i),
`endif
      .env_out   (env_out),
      .busy      (busy),
      .stage_idx (stage_idx),
      .eoc       (eoc)
   );

   env_ramp_seq #(
      .DEPTH (DEPTH), .STAGES (STAGES), .TW (TW), .TSCALE (3), .OUT_W (OUT_W)
   ) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena3),
      .trigger   (trig3),
      .levels    (levels),
      .times     (times),
`ifdef ENVSEQ_LOOP_EN
      .loop      (loop_i),
`endif
      .env_out   (env3),
      .busy      (busy3),
      .stage_idx (stage3),
      .eoc       (eoc3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance past n rising edges, landing on a falling edge.
   task automatic cyc(input int num);
      repeat (num) @(negedge clk);
   endtask

   initial begin
      // Asynchronous reset asserted mid-cycle, before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_env", env_out, 0);
      check("rst_busy", busy, 0);
      check("rst_eoc", eoc, 0);
      check("rst_stage", stage_idx, 0);
      cyc(2);
      rst = 1'b0;
      cyc(2);
      check("idle_busy", busy, 0);

      // Full run through all three stages.
      trigger = 1'b1;
      cyc(2);
      check("full_load_busy", busy, 1);
      check("full_load_env", env_out, 0);
      for (int i = 0; i < 7; i++) begin
         cyc(1);
         check($sformatf("full_env%0d", i), env_out, full_env[i]);
         check($sformatf("full_stage%0d", i), stage_idx, full_stage[i]);
         check($sformatf("full_eoc%0d", i), eoc, full_eoc[i]);
      end
      check("full_end_busy", busy, 0);
      cyc(1);
      check("full_eoc_clear", eoc, 0);

      // Retrigger in stage 0 at 15360: ramp restarts from there.
      trigger = 1'b0;
      cyc(2);
      trigger = 1'b1;
      cyc(1);
      trigger = 1'b0;
      cyc(1);
      check("rt_load_busy", busy, 1);
      cyc(1);
      check("rt_first", env_out, 7680);
      trigger = 1'b1;
      cyc(1);
      check("rt_before", env_out, 15360);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check($sformatf("rt_env%0d", i), env_out, retrig_env[i]);
      end
      cyc(3);
      check("rt_end_env", env_out, 0);
      check("rt_end_eoc", eoc, 1);

      // Enable held low mid-ramp freezes everything.
      trigger = 1'b0;
      cyc(1);
      trigger = 1'b1;
      cyc(4);
      check("ena_pre", env_out, 15360);
      ena = 1'b0;
      cyc(10);
      check("ena_frozen_env", env_out, 15360);
      check("ena_frozen_busy", busy, 1);
      ena = 1'b1;
      cyc(1);
      check("ena_resume1", env_out, 23040);
      cyc(1);
      check("ena_resume2", env_out, 30720);
      cyc(3);
      check("ena_end_env", env_out, 0);
      check("ena_end_eoc", eoc, 1);

      // Edge seen while disabled starts the envelope once enabled.
      trigger = 1'b0;
      cyc(1);
      ena = 1'b0;
      trigger = 1'b1;
      cyc(3);
      check("dis_idle_busy", busy, 0);
      check("dis_idle_env", env_out, 0);
      ena = 1'b1;
      cyc(1);
      check("dis_load_busy", busy, 1);
      cyc(1);
      check("dis_first", env_out, 7680);
      cyc(6);
      check("dis_end_env", env_out, 0);
      check("dis_end_eoc", eoc, 1);

      // Reset mid-ramp clears immediately; next trigger ramps from 0.
      trigger = 1'b0;
      cyc(1);
      trigger = 1'b1;
      cyc(5);
      check("mr_pre", env_out, 23040);
      #2 rst = 1'b1;
      trigger = 1'b0;
      #1;
      check("mr_env", env_out, 0);
      check("mr_busy", busy, 0);
      check("mr_stage", stage_idx, 0);
      #1 rst = 1'b0;
      cyc(3);
      check("mr_idle_busy", busy, 0);
      trigger = 1'b1;
      cyc(2);
      check("mr_load_env", env_out, 0);
      cyc(1);
      check("mr_first", env_out, 7680);
      cyc(6);
      check("mr_end_env", env_out, 0);
      check("mr_end_eoc", eoc, 1);

`ifdef ENVSEQ_LOOP_EN
      // Looping: after the final 0 the envelope climbs again.
      trigger = 1'b0;
      loop_i  = 1'b1;
      cyc(1);
      trigger = 1'b1;
      cyc(9);
      check("lp_pass_env", env_out, 0);
      check("lp_pass_eoc", eoc, 1);
      check("lp_pass_busy", busy, 1);
      check("lp_pass_stage", stage_idx, 0);
      cyc(4);
      check("lp_peak", env_out, 30720);
      check("lp_peak_eoc", eoc, 0);
      loop_i = 1'b0;
      cyc(3);
      check("lp_stop_env", env_out, 0);
      check("lp_stop_eoc", eoc, 1);
      check("lp_stop_busy", busy, 0);
`endif

      // Prescaler of 3: output moves every third clock.
      trig3 = 1'b1;
      n = 0;
      while (busy3 !== 1'b1 && n < 12) begin
         cyc(1);
         n++;
      end
      check("ts3_start", busy3, 1);
      check("ts3_load_env", env3, 0);
      cyc(2);
      check("ts3_hold0", env3, 0);
      cyc(1);
      check("ts3_step1", env3, 7680);
      cyc(2);
      check("ts3_hold1", env3, 7680);
      cyc(1);
      check("ts3_step2", env3, 15360);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
